// File: rtl/core_pkg.sv
// Shared core definitions: machine word size and memory-response ownership tags.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  // Identifies which requester owns the response returning this cycle
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IF    = 2'd1,
    OWN_DM_LD = 2'd2,
    OWN_DM_ST = 2'd3
  } resp_owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive cycles a fetch request has been denied.
module mem_arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [3:0] LIMIT_C = 4'(LIMIT);

  logic [3:0] cnt_d;
  logic [3:0] cnt_q;

  // Clear dominates; otherwise count up and hold at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data port.
// Data wins conflicts unless fetch has been starved for STARVE_LIMIT cycles.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [DATA_W/8-1:0]   dm_be,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  resp_owner_e owner_d;
  resp_owner_e owner_q;
  logic        at_limit;

  mem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (if_gnt | ~if_req),
    .inc      (if_req & ~if_gnt),
    .at_limit (at_limit)
  );

  // Grant selection: data priority, fetch forced through once starved
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst) begin
      if (dm_req && !(if_req && at_limit)) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Memory command mux driven from the granted port
  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_be    = dm_be;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_be    = '1;
      mem_addr  = if_addr;
    end
  end

  // Tag the owner of next cycle's response from this cycle's grant
  always_comb begin
    owner_d = OWN_NONE;
    if (dm_gnt) begin
      owner_d = dm_we ? OWN_DM_ST : OWN_DM_LD;
    end else if (if_gnt) begin
      owner_d = OWN_IF;
    end
  end

  // Owner register; reset drops any in-flight response
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Route returning read data to its owner, zero elsewhere
  always_comb begin
    if_rvalid = (owner_q == OWN_IF);
    dm_rvalid = (owner_q == OWN_DM_LD) || (owner_q == OWN_DM_ST);
    if_rdata  = (owner_q == OWN_IF)    ? mem_rdata : '0;
    dm_rdata  = (owner_q == OWN_DM_LD) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_LIMIT=4): cycle-by-cycle vector
// table plus hand-written starvation and reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .STARVE_LIMIT (4),
    .ADDR_W       (32),
    .DATA_W       (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_be     (dm_be),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  typedef struct packed {
    logic        if_gnt;
    logic        dm_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } out_t;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] mem_rdata;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic r, input logic ir, input logic [31:0] ia,
    input logic dr, input logic we, input logic [3:0] be,
    input logic [31:0] da, input logic [31:0] wd, input logic [31:0] rd,
    input logic ig, input logic dg, input logic irv, input logic [31:0] ird,
    input logic drv, input logic [31:0] drd, input logic en, input logic mwe,
    input logic [3:0] mbe, input logic [31:0] ma, input logic [31:0] mwd);
    vec_t t;
    t.rst = r; t.if_req = ir; t.if_addr = ia;
    t.dm_req = dr; t.dm_we = we; t.dm_be = be; t.dm_addr = da;
    t.dm_wdata = wd; t.mem_rdata = rd;
    t.exp = '{ig, dg, irv, ird, drv, drd, en, mwe, mbe, ma, mwd};
    return t;
  endfunction

  function automatic out_t actual();
    return '{if_gnt, dm_gnt, if_rvalid, if_rdata, dm_rvalid, dm_rdata,
             mem_en, mem_we, mem_be, mem_addr, mem_wdata};
  endfunction

  task automatic drive(input vec_t t);
    rst = t.rst; if_req = t.if_req; if_addr = t.if_addr;
    dm_req = t.dm_req; dm_we = t.dm_we; dm_be = t.dm_be;
    dm_addr = t.dm_addr; dm_wdata = t.dm_wdata; mem_rdata = t.mem_rdata;
  endtask

  task automatic check_out(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Advance to the next cycle: inputs after the edge, outputs sampled mid-cycle
  task automatic step(input vec_t t);
    @(posedge clk);
    #1;
    drive(t);
    #3;
  endtask

  task automatic idle_step(input logic r);
    step(v(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic both_step(input logic [31:0] ia, input logic [31:0] da);
    step(v(0, 1, ia, 1, 0, 4'hF, da, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    logic exp_if;
    out_t zero_o;
    zero_o = '0;

    //      rst ir ia     dr we be    da       wd         rd          ig dg irv ird    drv drd   en we be    ma       mwd
    vecs.push_back(v(1, 0, 0,     0, 0, 0,    0,       0,         0,          0, 0, 0, 0,     0, 0,     0, 0, 0,    0,       0));
    vecs.push_back(v(1, 1, 'h44,  0, 0, 0,    0,       0,         0,          0, 0, 0, 0,     0, 0,     0, 0, 0,    0,       0));
    // fetch only
    vecs.push_back(v(0, 1, 'h44,  0, 0, 0,    0,       0,         0,          1, 0, 0, 0,     0, 0,     1, 0, 4'hF, 'h44,    0));
    vecs.push_back(v(0, 0, 0,     0, 0, 0,    0,       0,         'h13,       0, 0, 1, 'h13,  0, 0,     0, 0, 0,    0,       0));
    vecs.push_back(v(0, 0, 0,     0, 0, 0,    0,       0,         'h55,       0, 0, 0, 0,     0, 0,     0, 0, 0,    0,       0));
    // conflict: data first, then fetch
    vecs.push_back(v(0, 1, 'h48,  1, 0, 4'hF, 'h100,   0,         0,          0, 1, 0, 0,     0, 0,     1, 0, 4'hF, 'h100,   0));
    vecs.push_back(v(0, 1, 'h48,  0, 0, 0,    0,       0,         'hCAFE0001, 1, 0, 0, 0,     1, 'hCAFE0001, 1, 0, 4'hF, 'h48, 0));
    vecs.push_back(v(0, 0, 0,     0, 0, 0,    0,       0,         'h93,       0, 0, 1, 'h93,  0, 0,     0, 0, 0,    0,       0));
    // store, then completion with zero data
    vecs.push_back(v(0, 0, 0,     1, 1, 4'h3, 'h2000,  'hDEADBEEF, 0,         0, 1, 0, 0,     0, 0,     1, 1, 4'h3, 'h2000,  'hDEADBEEF));
    vecs.push_back(v(0, 0, 0,     0, 0, 0,    0,       0,         'h12345678, 0, 0, 0, 0,     1, 0,     0, 0, 0,    0,       0));
    // back-to-back fetches
    vecs.push_back(v(0, 1, 'h0,   0, 0, 0,    0,       0,         0,          1, 0, 0, 0,     0, 0,     1, 0, 4'hF, 'h0,     0));
    vecs.push_back(v(0, 1, 'h4,   0, 0, 0,    0,       0,         'hA0,       1, 0, 1, 'hA0,  0, 0,     1, 0, 4'hF, 'h4,     0));
    vecs.push_back(v(0, 1, 'h8,   0, 0, 0,    0,       0,         'hA1,       1, 0, 1, 'hA1,  0, 0,     1, 0, 4'hF, 'h8,     0));
    vecs.push_back(v(0, 0, 0,     0, 0, 0,    0,       0,         'hA2,       0, 0, 1, 'hA2,  0, 0,     0, 0, 0,    0,       0));
    // two denials, fetch drops (counter clears), then full starvation run
    vecs.push_back(v(0, 1, 'h10,  1, 0, 4'hF, 'h200,   0,         0,          0, 1, 0, 0,     0, 0,     1, 0, 4'hF, 'h200,   0));
    vecs.push_back(v(0, 1, 'h10,  1, 0, 4'hF, 'h200,   0,         'h77,       0, 1, 0, 0,     1, 'h77,  1, 0, 4'hF, 'h200,   0));
    vecs.push_back(v(0, 0, 0,     1, 0, 4'hF, 'h200,   0,         0,          0, 1, 0, 0,     1, 0,     1, 0, 4'hF, 'h200,   0));
    for (int unsigned i = 0; i < 4; i++)
      vecs.push_back(v(0, 1, 'h10, 1, 0, 4'hF, 'h200,  0,         0,          0, 1, 0, 0,     1, 0,     1, 0, 4'hF, 'h200,   0));
    vecs.push_back(v(0, 1, 'h10,  1, 0, 4'hF, 'h200,   0,         0,          1, 0, 0, 0,     1, 0,     1, 0, 4'hF, 'h10,    0));
    vecs.push_back(v(0, 1, 'h10,  1, 0, 4'hF, 'h200,   0,         'h99,       0, 1, 1, 'h99,  0, 0,     1, 0, 4'hF, 'h200,   0));
    vecs.push_back(v(0, 0, 0,     0, 0, 0,    0,       0,         'h5,        0, 0, 0, 0,     1, 'h5,   0, 0, 0,    0,       0));

    rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
    dm_be = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    @(posedge clk);

    foreach (vecs[i]) begin
      step(vecs[i]);
      check_out($sformatf("vec%0d", i), actual(), vecs[i].exp);
    end

    // Starvation: both held for 10 cycles from a clear counter
    idle_step(1'b0);
    for (int unsigned c = 0; c < 10; c++) begin
      both_step(32'h80, 32'h300);
      exp_if = (c == 4) || (c == 9);
      check_bit($sformatf("starve_if_gnt_c%0d", c), if_gnt, exp_if);
      check_bit($sformatf("starve_dm_gnt_c%0d", c), dm_gnt, !exp_if);
    end

    // Reset mid-operation: build up starvation, reset while fetch requests
    idle_step(1'b0);
    both_step(32'h90, 32'h400);
    both_step(32'h90, 32'h400);
    step(v(1, 1, 'h90, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_bit("rst_if_gnt_forced_low", if_gnt, 1'b0);
    check_bit("rst_mem_en_low", mem_en, 1'b0);
    step(v(0, 0, 0, 0, 0, 0, 0, 0, 'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_out("post_rst_all_zero", actual(), zero_o);
    // Starve counter must be back at zero: four data wins before fetch
    for (int unsigned c = 0; c < 5; c++) begin
      both_step(32'h90, 32'h400);
      check_bit($sformatf("post_rst_if_gnt_c%0d", c), if_gnt, c == 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
